xgmii_tx_framer: RTL and testbench
==================================

Name: xgmii_tx_framer

Overview:
- Transmit-side framer: converts a 64-bit valid/ready frame stream (from host/PCIe side logic) into XGMII 64-bit ctrl/data toward the Ethernet port.
- Inserts start/preamble/SFD and terminate, enforces a minimum inter-frame gap, and aborts frames on underrun or malformed keep with XGMII error codes.
- Complements the RX path, which consumes XGMII and hands frames inward.

Parameters:
- MIN_IFG_CYCLES, 2, number of full idle words after the word carrying terminate (2 = 16 idle bytes, at least the 12-byte IEEE minimum).
- CNT_WIDTH, 32, width of the frame and error counters.

Ports:
- clk  input  1  single clock, 156.25 MHz XGMII domain.
- reset  input  1  synchronous, active-high reset.
- s_data  input  64  frame bytes; byte 0 in [7:0].
- s_keep  input  8  byte enables; only meaningful when s_last=1.
- s_valid  input  1  input word valid.
- s_last  input  1  last word of frame.
- s_ready  output  1  word accepted when s_valid&&s_ready.
- xgmii_ctrl  output  8  XGMII control, bit i corresponds to lane i.
- xgmii_data  output  64  XGMII data, lane i is [8i+7:8i].
- frame_count  output  CNT_WIDTH  frames completed without error; wraps.
- error_count  output  CNT_WIDTH  frames aborted; wraps.

Behaviour:
- Codes: IDLE 0x07, START 0xFB, TERM 0xFD, ERR 0xFE, preamble 0x55, SFD 0xD5. Idle word: ctrl=0xFF, data=0x0707070707070707.
- xgmii_ctrl and xgmii_data are registered. A word presented in cycle N appears at the outputs in cycle N+1.
- s_ready is combinational from state only. It is 1 in DATA and DROP, and 0 otherwise.
- Reset: state=IDLE, xgmii=idle word, s_ready=0, both counters=0, IFG counter=0. Reset mid-frame truncates output to idle immediately, with no terminate and no count.
- IDLE state:
  - Emit an idle word.
  - If s_valid=1, go to PREAMBLE. The input word is not consumed.
  - Start is always placed in lane 0.
- PREAMBLE state:
  - Emit ctrl=0x01, data=0xD5555555555555FB.
  - Go to DATA.
- DATA state, s_valid=1, s_last=0: emit the word with ctrl=0x00.
- DATA state, s_valid=1, s_last=1:
  - Let n = number of set keep bits. The keep is legal if it is contiguous from bit 0 (0x01, 0x03, …, 0xFF).
  - If legal and n<8: lanes 0..n-1 carry data with ctrl 0; lane n carries TERM; lanes above n carry IDLE. ctrl = ~((1<<n)-1). Increment frame_count, then go to IFG.
  - If legal and n=8: emit the data word with ctrl=0x00, then go to TERM.
  - If illegal (zero or non-contiguous): emit the ERR word (ctrl=0xFF, all lanes 0xFE). Increment error_count, go to ABORT.
- DATA state, s_valid=0 (underrun):
  - Emit the ERR word and increment error_count.
  - Go to ABORT, then DROP.
- TERM state:
  - Emit ctrl=0xFF, data=0x07070707070707FD.
  - Increment frame_count, then go to IFG.
- ABORT state:
  - Emit ctrl=0xFF, data=0x07070707070707FD.
  - If the last word was already consumed (illegal-keep path), go to IFG. Otherwise (underrun path) go to DROP.
- DROP state:
  - Emit idle words.
  - s_ready=1; discard words until a consumed word has s_last=1, then go to IFG.
  - An idle word is emitted in the cycle the last word is discarded.
- IFG state:
  - Emit idle words. The counter loads MIN_IFG_CYCLES on entry and decrements each cycle.
  - On the cycle it reaches 1, go to IDLE.
  - The earliest next START appears MIN_IFG_CYCLES+2 cycles after the terminate word (IFG cycles, plus IDLE, plus PREAMBLE).
- Counters increment exactly once per frame and wrap at 2^CNT_WIDTH.

Test Plan:
- Reset with s_valid=1 held → outputs ctrl=0xFF, data=0x0707…07, s_ready=0, counters 0 throughout reset; START appears 2 cycles after reset deasserts.
- 3-word frame, last keep=0x0F, words 0x1111…, 0x2222…, 0x33333333_44444444 → preamble word 0xD5555555555555FB/0x01, then two data words with ctrl=0x00, then ctrl=0xF0, data=0x070707FD_44444444; frame_count=1; next START no earlier than 4 cycles later.
- 1-word frame, keep=0xFF → preamble, data word with ctrl=0x00, then TERM word 0x07070707070707FD with ctrl=0xFF.
- s_valid dropped for 1 cycle mid-frame → ERR word (all 0xFE, ctrl=0xFF), then TERM word; remaining words accepted silently until s_last; error_count=1, frame_count unchanged.
- Last word with keep=0x05 → ERR word, TERM word, then IFG; error_count increments.
- Back-to-back frames with s_valid held high, keep=0x01 → terminate in lane 1; exactly MIN_IFG_CYCLES idle words, then IDLE and PREAMBLE; frame_count=2.

Source files
------------

// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: turns a 64-bit valid/ready frame stream into XGMII
// ctrl/data words. It adds start/preamble/SFD and terminate, holds a minimum
// inter-frame gap, and aborts frames on underrun or malformed keep.
module xgmii_tx_framer #(
  parameter int MIN_IFG_CYCLES = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          s_data,
  input  logic [7:0]           s_keep,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [7:0]           xgmii_ctrl,
  output logic [63:0]          xgmii_data,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] error_count
);

  localparam int IFG_W = (MIN_IFG_CYCLES < 2) ? 1 : $clog2(MIN_IFG_CYCLES + 1);

  localparam logic [7:0]  CTRL_ALL  = 8'hFF;
  localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;
  localparam logic [63:0] PRE_WORD  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_WORD = 64'h07070707070707FD;
  localparam logic [63:0] ERR_WORD  = 64'hFEFEFEFEFEFEFEFE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_TERM,
    S_ABORT,
    S_DROP,
    S_IFG
  } state_t;

  state_t             state, state_nxt;
  logic [IFG_W-1:0]   ifg_cnt;
  logic               last_seen, last_seen_nxt;
  logic               fc_inc, ec_inc;
  logic [7:0]         ctrl_p0;
  logic [63:0]        data_p0;
  logic [3:0]         keep_n;
  logic               keep_ok;

  // Keep must be a non-empty run of ones starting at bit 0.
  function automatic logic keep_legal(input logic [7:0] k);
    return (k != 8'd0) && ((k & (k + 8'd1)) == 8'd0);
  endfunction

  // Number of valid bytes in the last word.
  function automatic logic [3:0] keep_count(input logic [7:0] k);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, k[i]};
    end
    return n;
  endfunction

  // Control lanes for a short last word: data lanes clear, terminate and idles set.
  function automatic logic [7:0] term_ctrl(input logic [3:0] n);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      c[i] = (4'(i) >= n);
    end
    return c;
  endfunction

  // Data lanes for a short last word: n data bytes, terminate, then idles.
  function automatic logic [63:0] term_data(input logic [63:0] d, input logic [3:0] n);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n)
        w[8*i +: 8] = d[8*i +: 8];
      else if (4'(i) == n)
        w[8*i +: 8] = 8'hFD;
      else
        w[8*i +: 8] = 8'h07;
    end
    return w;
  endfunction

  assign keep_n  = keep_count(s_keep);
  assign keep_ok = keep_legal(s_keep);
  assign s_ready = (state == S_DATA) || (state == S_DROP);

  // Next-state and next output word selection.
  always_comb begin
    state_nxt     = state;
    last_seen_nxt = last_seen;
    ctrl_p0       = CTRL_ALL;
    data_p0       = IDLE_WORD;
    fc_inc        = 1'b0;
    ec_inc        = 1'b0;
    case (state)
      S_IDLE: begin
        if (s_valid) state_nxt = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        ctrl_p0   = 8'h01;
        data_p0   = PRE_WORD;
        state_nxt = S_DATA;
      end
      S_DATA: begin
        if (!s_valid) begin
          ctrl_p0       = CTRL_ALL;
          data_p0       = ERR_WORD;
          ec_inc        = 1'b1;
          last_seen_nxt = 1'b0;
          state_nxt     = S_ABORT;
        end else if (!s_last) begin
          ctrl_p0 = 8'h00;
          data_p0 = s_data;
        end else if (!keep_ok) begin
          ctrl_p0       = CTRL_ALL;
          data_p0       = ERR_WORD;
          ec_inc        = 1'b1;
          last_seen_nxt = 1'b1;
          state_nxt     = S_ABORT;
        end else if (keep_n == 4'd8) begin
          ctrl_p0   = 8'h00;
          data_p0   = s_data;
          state_nxt = S_TERM;
        end else begin
          ctrl_p0   = term_ctrl(keep_n);
          data_p0   = term_data(s_data, keep_n);
          fc_inc    = 1'b1;
          state_nxt = S_IFG;
        end
      end
      S_TERM: begin
        data_p0   = TERM_WORD;
        fc_inc    = 1'b1;
        state_nxt = S_IFG;
      end
      S_ABORT: begin
        data_p0   = TERM_WORD;
        state_nxt = last_seen ? S_IFG : S_DROP;
      end
      S_DROP: begin
        if (s_valid && s_last) state_nxt = S_IFG;
      end
      S_IFG: begin
        if (ifg_cnt <= IFG_W'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, gap counter and abort-path flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ifg_cnt   <= '0;
      last_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_seen <= last_seen_nxt;
      if (state_nxt == S_IFG && state != S_IFG)
        ifg_cnt <= IFG_W'(MIN_IFG_CYCLES);
      else if (state == S_IFG)
        ifg_cnt <= ifg_cnt - IFG_W'(1);
    end
  end

  // Output stage: registered XGMII word; reset forces idle at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      xgmii_ctrl <= CTRL_ALL;
      xgmii_data <= IDLE_WORD;
    end else begin
      xgmii_ctrl <= ctrl_p0;
      xgmii_data <= data_p0;
    end
  end

  // Frame and error counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      error_count <= '0;
    end else begin
      if (fc_inc) frame_count <= frame_count + CNT_WIDTH'(1);
      if (ec_inc) error_count <= error_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Directed bench for xgmii_tx_framer: each step drives one input cycle,
// queues the word expected at the outputs, and checks it after the edge.
module tb_xgmii_tx_framer;

  localparam int MIN_IFG = 2;
  localparam int CW      = 32;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W = 64'h07070707070707FD;
  localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   s_data;
  logic [7:0]    s_keep;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [7:0]    xgmii_ctrl;
  logic [63:0]   xgmii_data;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] error_count;

  xgmii_tx_framer #(.MIN_IFG_CYCLES(MIN_IFG), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_keep      (s_keep),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .xgmii_ctrl  (xgmii_ctrl),
    .xgmii_data  (xgmii_data),
    .frame_count (frame_count),
    .error_count (error_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    c;
    logic [63:0]   d;
    logic [CW-1:0] fc;
    logic [CW-1:0] ec;
  } exp_t;

  exp_t          sb[$];
  int            vectors    = 0;
  int            miscompares = 0;
  logic [CW-1:0] exp_fc = '0;
  logic [CW-1:0] exp_ec = '0;

  task automatic cyc(input string tag, input logic v, input logic l, input logic [7:0] k,
                     input logic [63:0] d, input logic rdy,
                     input logic [7:0] ec, input logic [63:0] ed);
    exp_t e;
    s_valid = v;
    s_last  = l;
    s_keep  = k;
    s_data  = d;
    #1;
    vectors++;
    assert (s_ready === rdy) else begin
      miscompares++;
      $error("FAIL %s s_ready got %0b want %0b", tag, s_ready, rdy);
    end
    sb.push_back('{ec, ed, exp_fc, exp_ec});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    assert (xgmii_ctrl === e.c) else begin
      miscompares++;
      $error("FAIL %s ctrl got %h want %h", tag, xgmii_ctrl, e.c);
    end
    vectors++;
    assert (xgmii_data === e.d) else begin
      miscompares++;
      $error("FAIL %s data got %h want %h", tag, xgmii_data, e.d);
    end
    vectors++;
    assert (frame_count === e.fc) else begin
      miscompares++;
      $error("FAIL %s frame_count got %0d want %0d", tag, frame_count, e.fc);
    end
    vectors++;
    assert (error_count === e.ec) else begin
      miscompares++;
      $error("FAIL %s error_count got %0d want %0d", tag, error_count, e.ec);
    end
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_keep  = 8'h00;
    s_data  = 64'h1111111111111111;
    @(posedge clk);
    #1;
    // Reset held with s_valid asserted: idle output, no ready, zero counters.
    cyc("rst0", 1, 0, 8'h00, 64'h1111111111111111, 0, 8'hFF, IDLE_W);
    cyc("rst1", 1, 0, 8'h00, 64'h1111111111111111, 0, 8'hFF, IDLE_W);
    cyc("rst2", 1, 0, 8'h00, 64'h1111111111111111, 0, 8'hFF, IDLE_W);
    reset = 1'b0;
    // Frame 1: three words, last keep 0x0F.
    cyc("f1_idle", 1, 0, 8'h00, 64'h1111111111111111, 0, 8'hFF, IDLE_W);
    cyc("f1_pre",  1, 0, 8'h00, 64'h1111111111111111, 0, 8'h01, PRE_W);
    cyc("f1_w0",   1, 0, 8'h00, 64'h1111111111111111, 1, 8'h00, 64'h1111111111111111);
    cyc("f1_w1",   1, 0, 8'h00, 64'h2222222222222222, 1, 8'h00, 64'h2222222222222222);
    exp_fc = 32'd1;
    cyc("f1_last", 1, 1, 8'h0F, 64'h3333333344444444, 1, 8'hF0, 64'h070707FD44444444);
    // Frame 2 waiting: gap of MIN_IFG idles plus IDLE before preamble.
    cyc("f2_ifg0", 1, 1, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 0, 8'hFF, IDLE_W);
    cyc("f2_ifg1", 1, 1, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 0, 8'hFF, IDLE_W);
    cyc("f2_idle", 1, 1, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 0, 8'hFF, IDLE_W);
    cyc("f2_pre",  1, 1, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 0, 8'h01, PRE_W);
    cyc("f2_w0",   1, 1, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 1, 8'h00, 64'hAAAAAAAAAAAAAAAA);
    exp_fc = 32'd2;
    cyc("f2_term", 0, 0, 8'h00, 64'h0, 0, 8'hFF, TERM_W);
    cyc("f2_ifg0", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("f2_ifg1", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("f2_idle", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    // Frame 3: underrun after one word, remainder dropped.
    cyc("f3_idle", 1, 0, 8'h00, 64'h5555555555555555, 0, 8'hFF, IDLE_W);
    cyc("f3_pre",  1, 0, 8'h00, 64'h5555555555555555, 0, 8'h01, PRE_W);
    cyc("f3_w0",   1, 0, 8'h00, 64'h5555555555555555, 1, 8'h00, 64'h5555555555555555);
    exp_ec = 32'd1;
    cyc("f3_err",  0, 0, 8'h00, 64'h0, 1, 8'hFF, ERR_W);
    cyc("f3_abrt", 1, 0, 8'h00, 64'h6666666666666666, 0, 8'hFF, TERM_W);
    cyc("f3_drp0", 1, 0, 8'h00, 64'h6666666666666666, 1, 8'hFF, IDLE_W);
    cyc("f3_drp1", 1, 1, 8'h03, 64'h7777777777777777, 1, 8'hFF, IDLE_W);
    cyc("f3_ifg0", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("f3_ifg1", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("f3_idle", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    // Frame 4: non-contiguous keep 0x05 on the last word.
    cyc("f4_idle", 1, 1, 8'h05, 64'h8888888888888888, 0, 8'hFF, IDLE_W);
    cyc("f4_pre",  1, 1, 8'h05, 64'h8888888888888888, 0, 8'h01, PRE_W);
    exp_ec = 32'd2;
    cyc("f4_err",  1, 1, 8'h05, 64'h8888888888888888, 1, 8'hFF, ERR_W);
    cyc("f4_abrt", 0, 0, 8'h00, 64'h0, 0, 8'hFF, TERM_W);
    cyc("f4_ifg0", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("f4_ifg1", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("f4_idle", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    // Frames 5 and 6: back-to-back one-byte frames, terminate in lane 1.
    cyc("f5_idle", 1, 1, 8'h01, 64'h00000000000000BB, 0, 8'hFF, IDLE_W);
    cyc("f5_pre",  1, 1, 8'h01, 64'h00000000000000BB, 0, 8'h01, PRE_W);
    exp_fc = 32'd3;
    cyc("f5_last", 1, 1, 8'h01, 64'h00000000000000BB, 1, 8'hFE, 64'h070707070707FDBB);
    cyc("f6_ifg0", 1, 1, 8'h01, 64'h12345678ABCDEFCC, 0, 8'hFF, IDLE_W);
    cyc("f6_ifg1", 1, 1, 8'h01, 64'h12345678ABCDEFCC, 0, 8'hFF, IDLE_W);
    cyc("f6_idle", 1, 1, 8'h01, 64'h12345678ABCDEFCC, 0, 8'hFF, IDLE_W);
    cyc("f6_pre",  1, 1, 8'h01, 64'h12345678ABCDEFCC, 0, 8'h01, PRE_W);
    exp_fc = 32'd4;
    cyc("f6_last", 1, 1, 8'h01, 64'h12345678ABCDEFCC, 1, 8'hFE, 64'h070707070707FDCC);
    cyc("f6_ifg0", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("f6_ifg1", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("f6_idle", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    // Frame 7: zero keep on the last word is an error.
    cyc("f7_idle", 1, 1, 8'h00, 64'h9999999999999999, 0, 8'hFF, IDLE_W);
    cyc("f7_pre",  1, 1, 8'h00, 64'h9999999999999999, 0, 8'h01, PRE_W);
    exp_ec = 32'd3;
    cyc("f7_err",  1, 1, 8'h00, 64'h9999999999999999, 1, 8'hFF, ERR_W);
    cyc("f7_abrt", 0, 0, 8'h00, 64'h0, 0, 8'hFF, TERM_W);
    cyc("f7_ifg0", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("f7_ifg1", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("f7_idle", 0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    // Frame 8: reset mid-frame truncates to idle with no terminate or count.
    cyc("f8_idle", 1, 0, 8'h00, 64'hDDDDDDDDDDDDDDDD, 0, 8'hFF, IDLE_W);
    cyc("f8_pre",  1, 0, 8'h00, 64'hDDDDDDDDDDDDDDDD, 0, 8'h01, PRE_W);
    cyc("f8_w0",   1, 0, 8'h00, 64'hDDDDDDDDDDDDDDDD, 1, 8'h00, 64'hDDDDDDDDDDDDDDDD);
    reset  = 1'b1;
    exp_fc = '0;
    exp_ec = '0;
    cyc("f8_rst0", 1, 0, 8'h00, 64'hEEEEEEEEEEEEEEEE, 1, 8'hFF, IDLE_W);
    cyc("f8_rst1", 1, 1, 8'h0F, 64'hEEEEEEEEEEEEEEEE, 0, 8'hFF, IDLE_W);
    reset = 1'b0;
    cyc("post_0",  0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    cyc("post_1",  0, 0, 8'h00, 64'h0, 0, 8'hFF, IDLE_W);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
